// File: rtl/wb_commit_if.sv
// Bundle of the MEM-stage input, load-return, register-file write and status
// signals exchanged between the pipeline (master) and the writeback block (slave).
interface wb_commit_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd_addr;
  logic        in_reg_write;
  logic [1:0]  in_wb_sel;
  logic [63:0] in_alu_result;
  logic [63:0] in_pc_plus4;
  logic [1:0]  in_ld_size;
  logic        in_ld_unsigned;
  logic [2:0]  in_byte_off;
  logic        ld_valid;
  logic [63:0] ld_data;
  logic        flush;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
  logic        wr_enable;
  logic        pend_valid;
  logic [4:0]  pend_addr;
  logic [63:0] instret;

  modport master (
    output in_valid, in_rd_addr, in_reg_write, in_wb_sel, in_alu_result,
           in_pc_plus4, in_ld_size, in_ld_unsigned, in_byte_off,
           ld_valid, ld_data, flush,
    input  in_ready, wr_addr, wr_data, wr_enable, pend_valid, pend_addr, instret
  );

  modport slave (
    input  in_valid, in_rd_addr, in_reg_write, in_wb_sel, in_alu_result,
           in_pc_plus4, in_ld_size, in_ld_unsigned, in_byte_off,
           ld_valid, ld_data, flush,
    output in_ready, wr_addr, wr_data, wr_enable, pend_valid, pend_addr, instret
  );
endinterface

// File: rtl/wb_commit.sv
// Writeback/commit stage: commits ALU/link results immediately, parks loads in
// WAIT_LD until data returns, then extracts and extends the addressed lane.
module wb_commit (
  input logic       clk,
  input logic       rst_n,
  wb_commit_if.slave bus
);

  typedef enum logic {IDLE, WAIT_LD} state_t;

  state_t      state_reg;
  logic [4:0]  wr_addr_reg;
  logic [63:0] wr_data_reg;
  logic        wr_enable_reg;
  logic        pend_valid_reg;
  logic [4:0]  pend_addr_reg;
  logic [63:0] instret_reg;
  logic        ld_write_reg;
  logic [1:0]  ld_size_reg;
  logic        ld_unsigned_reg;
  logic [2:0]  ld_off_reg;

  logic        accept;
  logic [63:0] alu_value;
  logic [5:0]  shift_amt;
  logic [63:0] shifted;
  logic        sign_ok;
  logic [63:0] ld_value;

  assign accept = bus.in_valid && (state_reg == IDLE) && !bus.flush;

  // wb_sel 11 falls back to the ALU result.
  assign alu_value = (bus.in_wb_sel == 2'b10) ? bus.in_pc_plus4 : bus.in_alu_result;

  // Narrow loads select their naturally aligned lane; low offset bits are ignored.
  always_comb begin
    shift_amt = 6'd0;
    case (ld_size_reg)
      2'b00:   shift_amt = {ld_off_reg, 3'b000};
      2'b01:   shift_amt = {ld_off_reg[2:1], 4'b0000};
      2'b10:   shift_amt = {ld_off_reg[2], 5'b00000};
      default: shift_amt = 6'd0;
    endcase
  end

  assign shifted = bus.ld_data >> shift_amt;
  assign sign_ok = !ld_unsigned_reg;

  always_comb begin
    ld_value = shifted;
    case (ld_size_reg)
      2'b00:   ld_value = {{56{sign_ok & shifted[7]}},  shifted[7:0]};
      2'b01:   ld_value = {{48{sign_ok & shifted[15]}}, shifted[15:0]};
      2'b10:   ld_value = {{32{sign_ok & shifted[31]}}, shifted[31:0]};
      default: ld_value = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      wr_addr_reg     <= 5'd0;
      wr_data_reg     <= 64'd0;
      wr_enable_reg   <= 1'b0;
      pend_valid_reg  <= 1'b0;
      pend_addr_reg   <= 5'd0;
      instret_reg     <= 64'd0;
      ld_write_reg    <= 1'b0;
      ld_size_reg     <= 2'b00;
      ld_unsigned_reg <= 1'b0;
      ld_off_reg      <= 3'd0;
    end else begin
      wr_enable_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (bus.in_wb_sel == 2'b01) begin
              state_reg       <= WAIT_LD;
              pend_valid_reg  <= 1'b1;
              pend_addr_reg   <= bus.in_rd_addr;
              ld_write_reg    <= bus.in_reg_write;
              ld_size_reg     <= bus.in_ld_size;
              ld_unsigned_reg <= bus.in_ld_unsigned;
              ld_off_reg      <= bus.in_byte_off;
            end else begin
              instret_reg <= instret_reg + 64'd1;
              // Address/data only move on a real write so they hold otherwise.
              if (bus.in_reg_write && (bus.in_rd_addr != 5'd0)) begin
                wr_enable_reg <= 1'b1;
                wr_addr_reg   <= bus.in_rd_addr;
                wr_data_reg   <= alu_value;
              end
            end
          end
        end
        WAIT_LD: begin
          if (bus.flush) begin
            state_reg      <= IDLE;
            pend_valid_reg <= 1'b0;
          end else if (bus.ld_valid) begin
            state_reg      <= IDLE;
            pend_valid_reg <= 1'b0;
            instret_reg    <= instret_reg + 64'd1;
            if (ld_write_reg && (pend_addr_reg != 5'd0)) begin
              wr_enable_reg <= 1'b1;
              wr_addr_reg   <= pend_addr_reg;
              wr_data_reg   <= ld_value;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (state_reg == IDLE);
  assign bus.wr_addr    = wr_addr_reg;
  assign bus.wr_data    = wr_data_reg;
  assign bus.wr_enable  = wr_enable_reg;
  assign bus.pend_valid = pend_valid_reg;
  assign bus.pend_addr  = pend_addr_reg;
  assign bus.instret    = instret_reg;

endmodule

// File: tb/tb_wb_commit.sv
// Directed plus random stimulus for wb_commit, compared each cycle against a
// transaction-level model (pending-load record, commit counter, expected write).
module tb_wb_commit;
  logic clk = 1'b0;
  logic rst_n;

  wb_commit_if bus();

  wb_commit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_pend;
  logic [4:0]  m_paddr;
  bit          m_rw;
  int          m_size;
  bit          m_uns;
  int          m_off;
  logic [63:0] m_instret;
  bit          m_wen;
  logic [4:0]  m_waddr;
  logic [63:0] m_wdata;
  bit          was_rst;
  logic [63:0] base_ir;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Load result from the rules: lane = offset rounded down to the access size.
  function automatic logic [63:0] ref_load(input logic [63:0] d, input int size,
                                           input bit uns, input int off);
    int          nbytes;
    int          lane;
    logic [63:0] v;
    logic [63:0] mask;
    nbytes = 1 << size;
    lane   = (off / nbytes) * nbytes;
    v      = d >> (8 * lane);
    if (nbytes < 8) begin
      mask = (64'd1 << (8 * nbytes)) - 64'd1;
      v = v & mask;
      if (!uns && v[8 * nbytes - 1]) v = v | ~mask;
    end
    return v;
  endfunction

  task automatic commit(input logic [4:0] rd, input bit rw, input logic [63:0] val);
    m_instret = m_instret + 64'd1;
    if (rw && rd != 5'd0) begin
      m_wen   = 1'b1;
      m_waddr = rd;
      m_wdata = val;
    end
  endtask

  // Advance the model with the currently driven inputs, clock once, compare.
  task automatic step();
    if (!rst_n) begin
      m_pend = 0; m_wen = 0; m_waddr = '0; m_wdata = '0; m_paddr = '0; m_instret = '0;
    end else begin
      m_wen = 0;
      if (!m_pend) begin
        if (bus.in_valid && !bus.flush) begin
          if (bus.in_wb_sel == 2'b01) begin
            m_pend  = 1;
            m_paddr = bus.in_rd_addr;
            m_rw    = bus.in_reg_write;
            m_size  = int'(bus.in_ld_size);
            m_uns   = bus.in_ld_unsigned;
            m_off   = int'(bus.in_byte_off);
          end else begin
            commit(bus.in_rd_addr, bus.in_reg_write,
                   (bus.in_wb_sel == 2'b10) ? bus.in_pc_plus4 : bus.in_alu_result);
          end
        end
      end else if (bus.flush) begin
        m_pend = 0;
      end else if (bus.ld_valid) begin
        commit(m_paddr, m_rw, ref_load(bus.ld_data, m_size, m_uns, m_off));
        m_pend = 0;
      end
    end
    was_rst = !rst_n;
    @(posedge clk);
    #1;
    chk("wr_enable",  {63'd0, bus.wr_enable},  {63'd0, m_wen});
    chk("in_ready",   {63'd0, bus.in_ready},   {63'd0, !m_pend});
    chk("pend_valid", {63'd0, bus.pend_valid}, {63'd0, m_pend});
    chk("instret",    bus.instret, m_instret);
    chk("wr_addr",    {59'd0, bus.wr_addr}, {59'd0, m_waddr});
    chk("wr_data",    bus.wr_data, m_wdata);
    if (m_pend || was_rst) chk("pend_addr", {59'd0, bus.pend_addr}, {59'd0, m_paddr});
  endtask

  task automatic idle_in();
    bus.in_valid = 0; bus.in_rd_addr = '0; bus.in_reg_write = 0; bus.in_wb_sel = '0;
    bus.in_alu_result = '0; bus.in_pc_plus4 = '0; bus.in_ld_size = '0;
    bus.in_ld_unsigned = 0; bus.in_byte_off = '0; bus.ld_valid = 0; bus.ld_data = '0;
    bus.flush = 0;
  endtask

  task automatic alu_op(input logic [4:0] rd, input bit rw, input logic [1:0] sel,
                        input logic [63:0] alu, input logic [63:0] pc);
    idle_in();
    bus.in_valid = 1; bus.in_rd_addr = rd; bus.in_reg_write = rw; bus.in_wb_sel = sel;
    bus.in_alu_result = alu; bus.in_pc_plus4 = pc;
  endtask

  task automatic load_op(input logic [4:0] rd, input logic [1:0] sz, input bit uns,
                         input logic [2:0] off);
    idle_in();
    bus.in_valid = 1; bus.in_rd_addr = rd; bus.in_reg_write = 1; bus.in_wb_sel = 2'b01;
    bus.in_ld_size = sz; bus.in_ld_unsigned = uns; bus.in_byte_off = off;
  endtask

  task automatic ld_return(input logic [63:0] d);
    idle_in();
    bus.ld_valid = 1; bus.ld_data = d;
  endtask

  initial begin
    rst_n = 0;
    idle_in();
    step();
    step();
    chk("rst_ready", {63'd0, bus.in_ready}, 64'd1);
    rst_n = 1;

    // ALU commit, rd=5
    alu_op(5'd5, 1, 2'b00, 64'h1234, 64'h0);
    step();
    chk("alu_wdata", bus.wr_data, 64'h1234);
    chk("alu_instret", bus.instret, 64'd1);
    idle_in(); step();

    // Signed byte load with four stall cycles, then unsigned variant
    load_op(5'd7, 2'b00, 0, 3'd3); step();
    idle_in(); repeat (4) step();
    chk("wait_pend_addr", {59'd0, bus.pend_addr}, 64'd7);
    ld_return(64'h0000_0000_8000_0000); step();
    chk("lb_signed", bus.wr_data, 64'hFFFF_FFFF_FFFF_FF80);
    load_op(5'd7, 2'b00, 1, 3'd3); step();
    idle_in(); repeat (4) step();
    ld_return(64'h0000_0000_8000_0000); step();
    chk("lb_unsigned", bus.wr_data, 64'h80);

    // Half load at offset 5 uses lane 2
    load_op(5'd9, 2'b01, 0, 3'd5); step();
    ld_return(64'h0000_BEEF_0000_0000); step();
    chk("lh_signed", bus.wr_data, 64'hFFFF_FFFF_FFFF_BEEF);

    // rd=0 and reg_write=0 commits count but never write
    base_ir = bus.instret;
    alu_op(5'd0, 1, 2'b00, 64'hAA, 64'h0); step();
    alu_op(5'd3, 0, 2'b00, 64'hBB, 64'h0); step();
    chk("nowrite_wen", {63'd0, bus.wr_enable}, 64'd0);
    chk("nowrite_instret", bus.instret, base_ir + 64'd2);

    // Back-to-back link and wb_sel=11 commits
    alu_op(5'd1, 1, 2'b10, 64'h11, 64'h4004); step();
    alu_op(5'd2, 1, 2'b11, 64'h22, 64'h4008); step();

    // Flush beats ld_valid in WAIT_LD
    load_op(5'd4, 2'b11, 0, 3'd0); step();
    base_ir = bus.instret;
    ld_return(64'hDEAD_BEEF_CAFE_F00D); bus.flush = 1; step();
    chk("flush_instret", bus.instret, base_ir);
    chk("flush_ready", {63'd0, bus.in_ready}, 64'd1);

    // ld_valid in IDLE ignored, flush in IDLE blocks accept, in_valid in WAIT_LD ignored
    ld_return(64'h1); step();
    alu_op(5'd6, 1, 2'b00, 64'h66, 64'h0); bus.flush = 1; step();
    load_op(5'd8, 2'b10, 1, 3'd4); step();
    alu_op(5'd10, 1, 2'b00, 64'h77, 64'h0); step();
    ld_return(64'h8765_4321_0000_0000); step();
    chk("lwu", bus.wr_data, 64'h8765_4321);

    // Reset during WAIT_LD with ld_valid high
    load_op(5'd12, 2'b11, 0, 3'd0); step();
    ld_return(64'h5555); rst_n = 0; step();
    chk("rst_wait_instret", bus.instret, 64'd0);
    rst_n = 1; idle_in(); step();

    // Random traffic
    repeat (400) begin
      idle_in();
      bus.in_valid       = ($urandom_range(0, 9) < 7);
      bus.in_rd_addr     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      bus.in_reg_write   = ($urandom_range(0, 4) != 0);
      bus.in_wb_sel      = 2'($urandom);
      bus.in_alu_result  = {$urandom, $urandom};
      bus.in_pc_plus4    = {$urandom, $urandom};
      bus.in_ld_size     = 2'($urandom);
      bus.in_ld_unsigned = 1'($urandom);
      bus.in_byte_off    = 3'($urandom);
      bus.ld_valid       = ($urandom_range(0, 9) < 4);
      bus.ld_data        = {$urandom, $urandom};
      bus.flush          = ($urandom_range(0, 9) == 0);
      rst_n              = ($urandom_range(0, 49) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
